// File: rtl/bp_nexus_msg_packer.sv
// Nexus trace message packer: serializes one TCODE/address/timestamp message into
// 8-bit {mseo, mdo} beats with leading-zero suppression on the variable fields.
module bp_nexus_msg_packer #(
   parameter int unsigned ts_width_p   = 16,
   parameter int unsigned addr_width_p = 64
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [5:0]              mcode_i,
   input  logic [addr_width_p-1:0] addr_i,
   input  logic [ts_width_p-1:0]   timestamp_i,
   input  logic                    msg_valid_i,
   output logic                    msg_ready_o,
   output logic [7:0]              beat_o,
   output logic                    beat_valid_o,
   input  logic                    beat_ready_i,
   output logic [31:0]             msg_count_o,
   output logic                    busy_o
);

   localparam int unsigned ACH    = (addr_width_p + 5) / 6;
   localparam int unsigned TCH    = (ts_width_p + 5) / 6;
   localparam int unsigned MAXCH  = (ACH > TCH) ? ACH : TCH;
   localparam int unsigned IDX_W  = $clog2(MAXCH + 1);
   localparam int unsigned AW_PAD = ACH * 6;
   localparam int unsigned TW_PAD = TCH * 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TCODE,
      S_ADDR,
      S_TS
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [5:0]         mcode_q;
   logic [AW_PAD-1:0]  addr_q;
   logic [TW_PAD-1:0]  ts_q;
   logic [IDX_W-1:0]   addr_n, ts_n;
   logic [5:0]         addr_chunk, ts_chunk;
   logic               last_addr, last_ts;
   logic               accept, eom_fire;

   // Fields are stored zero-padded to whole chunks so chunk selects never run off the end.
   always_comb begin
      addr_n = IDX_W'(1);
      for (int unsigned k = 0; k < ACH; k++) begin
         if (addr_q[6*k +: 6] != '0) addr_n = IDX_W'(k + 1);
      end
   end

   always_comb begin
      ts_n = IDX_W'(1);
      for (int unsigned k = 0; k < TCH; k++) begin
         if (ts_q[6*k +: 6] != '0) ts_n = IDX_W'(k + 1);
      end
   end

   always_comb begin
      addr_chunk = '0;
      for (int unsigned k = 0; k < ACH; k++) begin
         if (idx_q == IDX_W'(k)) addr_chunk = addr_q[6*k +: 6];
      end
   end

   always_comb begin
      ts_chunk = '0;
      for (int unsigned k = 0; k < TCH; k++) begin
         if (idx_q == IDX_W'(k)) ts_chunk = ts_q[6*k +: 6];
      end
   end

   assign last_addr = (idx_q == addr_n - IDX_W'(1));
   assign last_ts   = (idx_q == ts_n - IDX_W'(1));

   // End-of-message accept frees the holding registers in the same cycle.
   assign eom_fire    = (state_q == S_TS) && last_ts && beat_ready_i;
   assign msg_ready_o = (state_q == S_IDLE) || eom_fire;
   assign accept      = msg_valid_i && msg_ready_o;
   assign busy_o      = (state_q != S_IDLE);

   always_comb begin
      beat_o       = '0;
      beat_valid_o = 1'b0;
      case (state_q)
         S_TCODE: begin
            beat_o       = {2'b00, mcode_q};
            beat_valid_o = 1'b1;
         end
         S_ADDR: begin
            beat_o       = {(last_addr ? 2'b01 : 2'b00), addr_chunk};
            beat_valid_o = 1'b1;
         end
         S_TS: begin
            beat_o       = {(last_ts ? 2'b11 : 2'b00), ts_chunk};
            beat_valid_o = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_TCODE;
         end
         S_TCODE: begin
            if (beat_ready_i) begin
               state_d = S_ADDR;
               idx_d   = '0;
            end
         end
         S_ADDR: begin
            if (beat_ready_i) begin
               if (last_addr) begin
                  state_d = S_TS;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_TS: begin
            if (beat_ready_i) begin
               if (last_ts) begin
                  state_d = accept ? S_TCODE : S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         mcode_q     <= '0;
         addr_q      <= '0;
         ts_q        <= '0;
         msg_count_o <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (accept) begin
            mcode_q <= mcode_i;
            addr_q  <= AW_PAD'(addr_i);
            ts_q    <= TW_PAD'(timestamp_i);
         end
         if (eom_fire) msg_count_o <= msg_count_o + 32'd1;
      end
   end

endmodule
